// File: rtl/mem_pkg.sv
// Shared store-path encodings, buffer entry layout and lane-narrowing helpers.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int MEM_AW = 32;

    typedef struct packed {
        logic [MEM_AW-1:2] addr;
        logic [31:0]       wdata;
        logic [3:0]        be;
    } st_entry_t;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return a[0];
            SZ_WORD: return a != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] a);
        case (size)
            SZ_BYTE: return 4'b0001 << a;
            SZ_HALF: return 4'b0011 << {a[1], 1'b0};
            SZ_WORD: return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Replicate the narrow value across lanes so memory picks it up via be alone.
    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] d);
        case (size)
            SZ_BYTE: return {4{d[7:0]}};
            SZ_HALF: return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/store_narrow_buffer_fifo.sv
// Parameterised synchronous FIFO with registered count; head is always visible on rdata.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing is read unless count says it was written.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/store_narrow_buffer.sv
// Narrows store data to byte/half/word lanes, queues it, and drains to data memory
// one write at a time over a req/ack handshake.
module store_narrow_buffer
    import mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          st_valid,
    output logic          st_ready,
    input  logic [1:0]    st_size,
    input  logic [AW-1:0] st_addr,
    input  logic [31:0]   st_data,
    output logic          st_misalign,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_be,
    input  logic          mem_ack,
    output logic          buf_empty
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    localparam logic S_IDLE = 1'b0;
    localparam logic S_REQ  = 1'b1;

    typedef struct packed {
        logic [AW-1:2] addr;
        logic [31:0]   wdata;
        logic [3:0]    be;
    } entry_t;

    entry_t        push_entry, head;
    logic [CW-1:0] count;
    logic          accept, misal, push, pop;

    logic          state_q, state_d;
    logic          mem_req_q, mem_req_d;
    logic [AW-1:2] mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic [3:0]    mem_be_q, mem_be_d;
    logic          misalign_q, misalign_d;

    // Ready depends only on registered count so it never sees this cycle's ack.
    assign st_ready = (count != FULL);
    assign accept   = st_valid && st_ready;
    assign misal    = is_misaligned(st_size, st_addr[1:0]);
    assign push     = accept && !misal;

    always_comb begin
        push_entry.addr  = st_addr[AW-1:2];
        push_entry.wdata = lane_wdata(st_size, st_data);
        push_entry.be    = lane_be(st_size, st_addr[1:0]);
    end

    sync_fifo #(.DEPTH(DEPTH), .WIDTH($bits(entry_t))) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (push_entry),
        .rdata (head),
        .count (count)
    );

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        pop         = 1'b0;
        misalign_d  = accept && misal;
        case (state_q)
            S_IDLE: begin
                if (count != '0) begin
                    state_d     = S_REQ;
                    mem_req_d   = 1'b1;
                    mem_addr_d  = head.addr;
                    mem_wdata_d = head.wdata;
                    mem_be_d    = head.be;
                end
            end
            default: begin
                // Returning to IDLE on ack gives the mandatory bubble between writes.
                if (mem_ack) begin
                    pop       = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            misalign_q  <= misalign_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = {mem_addr_q, 2'b00};
    assign mem_wdata   = mem_wdata_q;
    assign mem_be      = mem_be_q;
    assign st_misalign = misalign_q;
    assign buf_empty   = (count == '0) && (state_q == S_IDLE);

endmodule

// File: doc/store_narrow_buffer.md
Name: store_narrow_buffer

Overview:
- Store-side counterpart of the load-path sign extension: takes 32-bit register data from the store stage and narrows it to byte, halfword or word lanes.
- Generates byte enables and buffers stores in a small FIFO.
- Drains the FIFO to data memory over a req/ack handshake, so the core does not stall on memory write latency.
- Sits between the EX/MEM store stage and the data-memory write port.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, 2..16.
- AW, 32, byte-address width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, synchronous, active-low.
- st_valid  input  1  store request from pipeline.
- st_ready  output  1  buffer can accept a store this cycle.
- st_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
- st_addr  input  AW  byte address.
- st_data  input  32  register rt value; low bits used for narrow stores.
- st_misalign  output  1  one-cycle pulse: the accepted store was misaligned or illegal and was dropped.
- mem_req  output  1  write request to data memory.
- mem_addr  output  AW  word-aligned address (bits [1:0] = 00).
- mem_wdata  output  32  lane-replicated write data.
- mem_be  output  4  byte enables, bit k = byte lane k (little-endian).
- mem_ack  input  1  memory accepted the current write.
- buf_empty  output  1  FIFO empty and no write outstanding.

Behaviour:
- Reset (rst_n low at a clk edge):
  - FIFO pointers and count go to 0; FSM goes to IDLE.
  - mem_req=0, mem_addr=0, mem_wdata=0, mem_be=0, st_misalign=0, st_ready=1, buf_empty=1.
  - Reset mid-transaction abandons the in-flight write and every buffered entry; mem_ack during reset is ignored.
- Accept rules:
  - A store is accepted when st_valid && st_ready.
  - st_ready = (count != DEPTH), derived from registered count only.
- Narrowing, computed at accept time and stored in the entry:
  - byte: be = 4'b0001 << addr[1:0]; wdata = {4{data[7:0]}}.
  - half: be = 4'b0011 << (2*addr[1]); wdata = {2{data[15:0]}}.
  - word: be = 4'b1111; wdata = data.
  - mem_addr = {addr[AW-1:2], 2'b00}.
- Misalign:
  - Triggers on: half with addr[0]=1; word with addr[1:0]!=0; size 11.
  - The store is still accepted (handshake completes) but is not written to the FIFO.
  - st_misalign pulses high the cycle after acceptance.
- Drain FSM:
  - IDLE: if count!=0 -> REQ; load mem_addr/mem_wdata/mem_be from the FIFO head; mem_req=1.
  - REQ: hold mem_req and all mem_* outputs stable until mem_ack=1.
  - On ack: pop the head, drop mem_req next cycle, return to IDLE.
  - Each write costs at least 2 cycles: one bubble cycle with mem_req=0 between consecutive writes.
- Latency: a store accepted at edge N into an empty, IDLE buffer shows mem_req=1 after edge N+1.
- Simultaneous push and pop (ack) in one cycle: count is unchanged and both take effect.
  - When full, push is blocked by st_ready=0, even if an ack frees a slot that cycle; no combinational ready.
- Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- buf_empty = (count==0) && state==IDLE.
- mem_ack while mem_req=0 is ignored.
- Ordering: writes leave strictly in acceptance order.

Decomposition:
- Shared package `mem_pkg`:
  - st_size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - Packed entry typedef {addr[AW-1:2], wdata[31:0], be[3:0]}.
- One natural sub-module, `sync_fifo`: a parameterised DEPTH x entry FIFO with push/pop/count.
- Lane narrowing and the drain FSM stay in the top module.

Test Plan:
- Byte store: size=00, addr=0x1003, data=0x123456AB, mem_ack one cycle after req -> mem_addr=0x1000, be=1000, wdata=0xABABABAB; buf_empty returns to 1.
- Half store: size=01, addr=0x2002, data=0xFFFF8001 -> mem_addr=0x2000, be=1100, wdata=0x80018001. Then word store: addr=0x2004, data=0xDEADBEEF -> be=1111, wdata=0xDEADBEEF, issued after one bubble cycle.
- Misalign: half at addr 0x3001, then word at 0x3002, then size=11 -> three st_misalign pulses; mem_req never asserted; buf_empty stays 1.
- Backpressure: hold mem_ack=0 and push 5 word stores with DEPTH=4.
  - st_ready drops after the 4th accept and the 5th stalls.
  - Ack once -> st_ready rises the next cycle and the 5th is accepted.
  - All 5 writes leave in order with correct addresses.
- Simultaneous push/pop: count=2 and mem_ack=1 in the same cycle as an accepted store -> count stays 2; the next write is the former second entry.
- Reset mid-operation: 3 entries queued and mem_req high; rst_n=0 for 1 cycle -> mem_req=0, buf_empty=1, st_ready=1; no stale write issued afterwards.
